// File: rtl/segments2data.sv
// segments2data: snoops a scanned multiplexed 7-segment bus (one-hot digit
// select plus segment map), captures one settled code per digit position and,
// once every position has been seen, converts the decimal text (with optional
// leading minus) back into a binary word.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// COLLECT | capture settled codes until every position has been seen
// CONVERT | walk positions MSB..LSB, accumulate decimal value, flag errors
// RESULT  | range check, pulse Valid, publish Data/Error, clear accumulator
module segments2data #(
  parameter int    Size         = 4,
  parameter string Signed       = "Yes",
  parameter int    SettleCycles = 2,
  // magnitude whose decimal digit count sets the number of positions
  localparam longint unsigned Mag = (Signed == "No") ? (64'd1 << Size)
                                                     : (64'd1 << (Size - 1)),
  localparam int Digits10 = (Mag <= 64'd1)          ? 0 :
                            (Mag <= 64'd10)         ? 1 :
                            (Mag <= 64'd100)        ? 2 :
                            (Mag <= 64'd1000)       ? 3 :
                            (Mag <= 64'd10000)      ? 4 :
                            (Mag <= 64'd100000)     ? 5 :
                            (Mag <= 64'd1000000)    ? 6 :
                            (Mag <= 64'd10000000)   ? 7 :
                            (Mag <= 64'd100000000)  ? 8 :
                            (Mag <= 64'd1000000000) ? 9 : 10,
  localparam int ISize = (Signed == "No") ? Digits10 : Digits10 + 1
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic [ISize-1:0] Indicators,
  input  logic [7:0]       Segments,
  output logic [Size-1:0]  Data,
  output logic             Valid,
  output logic             Error
);

  // bits needed to hold 10^n - 1
  function automatic int acc_width(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return $clog2(p);
  endfunction

  localparam bit IS_SIGNED = (Signed != "No");
  localparam int ACC_W     = acc_width(ISize);
  localparam int CMP_W     = (ACC_W > Size + 1) ? ACC_W : Size + 1;
  localparam int IDX_W     = (ISize > 1) ? $clog2(ISize) : 1;
  localparam int CNT_W     = $clog2(SettleCycles + 1);

  localparam logic [CMP_W-1:0] LIM_POS = IS_SIGNED ?
                                         CMP_W'((64'd1 << (Size - 1)) - 64'd1) :
                                         CMP_W'((64'd1 << Size) - 64'd1);
  localparam logic [CMP_W-1:0] LIM_NEG = CMP_W'(64'd1 << (Size - 1));

  typedef enum logic [1:0] {COLLECT, CONVERT, RESULT} state_t;

  state_t                 state;
  logic [ISize-1:0]       ind_q, ind_p;
  logic [6:0]             seg_q, seg_p;
  logic                   dp_unused;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic                   stable, capture;
  logic [IDX_W-1:0]       sel_idx, conv_idx;
  logic [ISize-1:0]       captured;
  logic [ISize-1:0][6:0]  codes;
  logic [ACC_W-1:0]       acc;
  logic                   neg, err_flag, started, got_digit;
  logic [6:0]             cur_code;
  logic                   is_blank, is_minus, dig_ok;
  logic [3:0]             dig_val;
  logic [CMP_W-1:0]       acc_ext, acc_neg;
  logic                   range_fail, err_final;

  // decimal point carries no value information
  assign dp_unused = Segments[7];

  // register the bus once and keep the previous sample for stability compare
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ind_q <= '0;
      seg_q <= '0;
      ind_p <= '0;
      seg_p <= '0;
    end else begin
      ind_q <= Indicators;
      seg_q <= Segments[6:0];
      ind_p <= ind_q;
      seg_p <= seg_q;
    end
  end

  // settle counting: counts consecutive identical one-hot samples
  always_comb begin
    stable   = $onehot(ind_q) && (ind_q == ind_p) && (seg_q == seg_p);
    cnt_next = '0;
    if (state != CONVERT && stable) begin
      if (cnt == CNT_W'(SettleCycles)) cnt_next = cnt;
      else                             cnt_next = cnt + CNT_W'(1);
    end
    // captures only while collecting; RESULT is left idle to keep pulse spacing
    capture = (state == COLLECT) && $onehot(ind_q) &&
              (cnt_next == CNT_W'(SettleCycles - 1));
  end

  // settle counter register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) cnt <= '0;
    else         cnt <= cnt_next;
  end

  // one-hot select to position index
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < ISize; i++) begin
      if (ind_q[i]) sel_idx = IDX_W'(i);
    end
  end

  // classify the code of the position currently being converted
  always_comb begin
    cur_code = codes[conv_idx];
    is_blank = (cur_code == 7'h00);
    is_minus = (cur_code == 7'h40);
    dig_ok   = 1'b1;
    dig_val  = 4'd0;
    case (cur_code)
      7'h3F:   dig_val = 4'd0;
      7'h06:   dig_val = 4'd1;
      7'h5B:   dig_val = 4'd2;
      7'h4F:   dig_val = 4'd3;
      7'h66:   dig_val = 4'd4;
      7'h6D:   dig_val = 4'd5;
      7'h7D:   dig_val = 4'd6;
      7'h07:   dig_val = 4'd7;
      7'h7F:   dig_val = 4'd8;
      7'h6F:   dig_val = 4'd9;
      default: dig_ok  = 1'b0;
    endcase
  end

  // final range check and negation of the accumulated magnitude
  always_comb begin
    acc_ext    = CMP_W'(acc);
    acc_neg    = ~acc_ext + CMP_W'(1);
    range_fail = neg ? (acc_ext > LIM_NEG) : (acc_ext > LIM_POS);
    // an all-blank frame or a bare minus never produced a digit
    err_final  = err_flag || !got_digit || range_fail;
  end

  // frame sequencing: capture, convert, publish
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= COLLECT;
      captured  <= '0;
      codes     <= '0;
      conv_idx  <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      err_flag  <= 1'b0;
      started   <= 1'b0;
      got_digit <= 1'b0;
      Data      <= '0;
      Valid     <= 1'b0;
      Error     <= 1'b0;
    end else begin
      Valid <= 1'b0;
      case (state)
        COLLECT: begin
          if (capture) begin
            codes[sel_idx] <= seg_q;
            if ((captured | ind_q) == {ISize{1'b1}}) begin
              captured <= '0;
              conv_idx <= IDX_W'(ISize - 1);
              state    <= CONVERT;
            end else begin
              captured <= captured | ind_q;
            end
          end
        end
        CONVERT: begin
          if (is_blank) begin
            if (started) err_flag <= 1'b1;
          end else if (is_minus) begin
            if (started || !IS_SIGNED) err_flag <= 1'b1;
            else                       neg      <= 1'b1;
            started <= 1'b1;
          end else if (dig_ok) begin
            acc       <= acc * ACC_W'(10) + ACC_W'(dig_val);
            started   <= 1'b1;
            got_digit <= 1'b1;
          end else begin
            err_flag <= 1'b1;
          end
          if (conv_idx == '0) state    <= RESULT;
          else                conv_idx <= conv_idx - IDX_W'(1);
        end
        RESULT: begin
          Valid <= 1'b1;
          Error <= err_final;
          if (!err_final) Data <= neg ? acc_neg[Size-1:0] : acc_ext[Size-1:0];
          acc       <= '0;
          neg       <= 1'b0;
          err_flag  <= 1'b0;
          started   <= 1'b0;
          got_digit <= 1'b0;
          state     <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_segments2data.sv
// Bench for segments2data (Size=4, signed, two positions, settle of 2).
// Frames are rendered as display text and parsed by a text-level model; the
// expected result is queued on issue and a monitor pops it on every Valid.
module tb_segments2data;

  localparam int ISZ = 2;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic [1:0] Indicators = '0;
  logic [7:0] Segments = '0;
  logic [3:0] Data;
  logic       Valid;
  logic       Error;

  segments2data dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .Indicators (Indicators),
    .Segments   (Segments),
    .Data       (Data),
    .Valid      (Valid),
    .Error      (Error)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0] data;
    bit         err;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         valid_cyc = -1;
  logic [3:0] hold_data = '0;
  bit         hold_err = 1'b0;
  logic [3:0] model_last = '0;
  bit         prev_valid = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---- text-level reference model ----
  function automatic byte code2ch(input logic [6:0] c);
    if (c == 7'h40) return 8'h2D;   // '-'
    if (c == 7'h00) return 8'h20;   // ' '
    for (int d = 0; d < 10; d++) if (c == seg_tab[d]) return byte'(48 + d);
    return 8'h3F;                   // '?'
  endfunction

  function automatic void model(input logic [1:0][6:0] c, output bit err, output int val);
    byte txt [ISZ];
    int  i;
    bit  neg;
    for (int p = 0; p < ISZ; p++) txt[p] = code2ch(c[ISZ-1-p]);
    i = 0; neg = 0; err = 0; val = 0;
    while (i < ISZ && txt[i] == 8'h20) i++;
    if (i < ISZ && txt[i] == 8'h2D) begin neg = 1; i++; end
    if (i == ISZ) err = 1;
    for (; i < ISZ; i++) begin
      if (txt[i] >= 8'h30 && txt[i] <= 8'h39) val = val * 10 + (txt[i] - 8'h30);
      else err = 1;
    end
    if (neg) begin
      if (val > 8) err = 1;
      val = -val;
    end else if (val > 7) begin
      err = 1;
    end
  endfunction

  function automatic logic [1:0][6:0] render(input int v);
    logic [1:0][6:0] c;
    int m;
    m = (v < 0) ? -v : v;
    c[0] = seg_tab[m % 10];
    if (v < 0)        c[1] = 7'h40;
    else if (m >= 10) c[1] = seg_tab[m / 10];
    else              c[1] = 7'h00;
    return c;
  endfunction

  function automatic logic [6:0] rand_code();
    logic [6:0] c;
    int k;
    k = $urandom_range(0, 9);
    if (k < 6)  return seg_tab[$urandom_range(0, 9)];
    if (k == 6) return 7'h40;
    if (k == 7) return 7'h00;
    do c = 7'($urandom); while (code2ch(c) != 8'h3F);
    return c;
  endfunction

  task automatic push_expect(input logic [1:0][6:0] c);
    bit   err;
    int   val;
    exp_t e;
    model(c, err, val);
    if (!err) model_last = 4'(val);
    e.err  = err;
    e.data = model_last;
    exp_q.push_back(e);
  endtask

  // ---- stimulus helpers (called at a falling edge) ----
  task automatic show(input logic [1:0] ind, input logic [6:0] seg, input int n);
    Indicators = ind;
    Segments   = {1'($urandom_range(0, 1)), seg};
    repeat (n) @(negedge Clock);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge Clock);
      n++;
    end
    check("valid_timeout_outstanding", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send_frame(input logic [1:0][6:0] c, input bit rev);
    push_expect(c);
    if (rev) begin
      show(2'b10, c[1], 3);
      show(2'b01, c[0], 3);
    end else begin
      show(2'b01, c[0], 3);
      show(2'b10, c[1], 3);
    end
    show(2'b00, 7'h00, 3);
    drain();
  endtask

  // ---- monitor / scoreboard ----
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      if (!nReset) begin
        prev_valid = 1'b0;
      end else begin
        if (Valid) begin
          check("valid_back_to_back", 32'(prev_valid), 0);
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("data", 32'(Data), 32'(e.data));
            check("error", 32'(Error), 32'(e.err));
            hold_data = e.data;
            hold_err  = e.err;
            valid_cyc = cyc;
          end
        end else begin
          check("data_hold", 32'(Data), 32'(hold_data));
          check("error_hold", 32'(Error), 32'(hold_err));
        end
        prev_valid = Valid;
      end
    end
  end

  // ---- main sequence ----
  initial begin : stim
    int cyc0;
    logic [1:0][6:0] c;

    repeat (3) @(negedge Clock);
    check("reset_data", 32'(Data), 0);
    check("reset_valid", 32'(Valid), 0);
    check("reset_error", 32'(Error), 0);
    nReset = 1'b1;
    @(negedge Clock);

    // positive "1" with result latency
    c = {7'h00, 7'h06};
    push_expect(c);
    show(2'b01, 7'h06, 3);
    cyc0 = cyc;
    show(2'b10, 7'h00, 3);
    show(2'b00, 7'h00, 3);
    drain();
    check("result_latency", valid_cyc - cyc0, 6);

    // negative, range boundary, out of range
    send_frame({7'h40, 7'h07}, 1'b0);
    send_frame({7'h40, 7'h7F}, 1'b0);
    send_frame({7'h00, 7'h7F}, 1'b1);

    // illegal code then a legal frame
    send_frame({7'h00, 7'h49}, 1'b0);
    send_frame({7'h00, 7'h4F}, 1'b0);

    // glitches: short select, non-one-hot select; only position 1 settles
    show(2'b01, 7'h06, 1);
    show(2'b00, 7'h00, 4);
    show(2'b11, 7'h06, 5);
    show(2'b00, 7'h00, 2);
    show(2'b10, 7'h00, 3);
    show(2'b00, 7'h00, 12);
    // position 0 alone now completes the frame
    push_expect({7'h00, 7'h6D});
    show(2'b01, 7'h6D, 3);
    show(2'b00, 7'h00, 3);
    drain();

    // reset during CONVERT
    show(2'b01, 7'h5B, 3);
    show(2'b10, 7'h00, 3);
    Indicators = 2'b00;
    #2;
    nReset     = 1'b0;
    hold_data  = '0;
    hold_err   = 1'b0;
    model_last = '0;
    #1;
    check("midreset_data", 32'(Data), 0);
    check("midreset_valid", 32'(Valid), 0);
    check("midreset_error", 32'(Error), 0);
    @(negedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
    show(2'b00, 7'h00, 15);

    // full sweep of representable display values
    for (int v = -7; v <= 7; v++) send_frame(render(v), 1'b0);

    // randomized frames
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 1) == 0) c = render($urandom_range(0, 24) - 9);
      else                           c = {rand_code(), rand_code()};
      send_frame(c, 1'($urandom_range(0, 1)));
    end

    show(2'b00, 7'h00, 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/segments2data.md
# segments2data

Reverse decoder for the multiplexed 7-segment display interface driven by `Data2Segments`. It snoops the scanned `Indicators`/`Segments` bus and captures one digit per indicator position. Once a full scan frame is captured, it converts the decimal digits and optional minus sign back into a `Size`-bit binary value. It is used as a loop-back checker behind the display driver and as a front end for reading values off existing display buses.

## Interface
Parameters:
- `Size`, 4: width of the reconstructed `Data` word.
- `Signed`, "Yes": "Yes" means two's-complement output and a minus sign is legal; "No" means unsigned.
- `ISize`, derived: number of digit positions. For `Signed`="No" it is `General1::clog10(1<<Size)`; otherwise it is `General1::clog10(1<<(Size-1))+1`.
- `SettleCycles`, 2: number of consecutive identical, valid samples required before a digit is captured (≥1).

Ports:
- `Clock`, input, 1: single clock. All inputs are synchronous to it.
- `nReset`, input, 1: asynchronous, active-low reset.
- `Indicators`, input, `ISize`: one-hot digit select, active high. Bit 0 is the least-significant digit.
- `Segments`, input, 8: segment map, active high. Bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g. Bit 7 (dp) is ignored.
- `Data`, output, `Size`: last successfully decoded value.
- `Valid`, output, 1: one-cycle pulse when a frame result is produced.
- `Error`, output, 1: status of the last frame. It is updated together with `Valid`.

## Operation
- Inputs are registered once. All decisions use the registered copies.
- Legal `Segments[6:0]` codes:
  - Digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - Minus: 40.
  - Blank: 00.
  - Any other code is illegal.
- Settle counter:
  - It increments while `Indicators` is one-hot and the `{Indicators, Segments[6:0]}` pair equals the previous cycle's pair.
  - It resets to 0 on any change, or when `Indicators` is zero or not one-hot.
- Capture: when the counter reaches `SettleCycles-1`, the code for that position is stored in a per-position register and the position's bit is set in a `Captured` mask. Each position is captured once per frame. Recapturing an already-set position overwrites its code.
- The FSM has three states:
  - COLLECT: captures digits. When `Captured` is all ones, go to CONVERT and clear `Captured`.
  - CONVERT: lasts `ISize` cycles and processes positions from most significant (`ISize-1`) down to 0.
    - Leading blanks are skipped.
    - A minus is accepted only as the first non-blank code, and only when `Signed`="Yes". It sets `Neg`.
    - For each digit, `Acc = Acc*10 + d`. `Acc` is wide enough to hold `10^ISize-1`.
    - Any of the following sets `ErrFlag`: an illegal code, a blank after a non-blank, a misplaced or disallowed minus, a frame that is all blank, or a frame that is a bare minus.
    - Captures are suspended in this state and the settle counter is held at 0.
  - RESULT: lasts 1 cycle, then returns to COLLECT.
- RESULT actions:
  - Range check. Unsigned: `Acc` ≤ 2^Size−1. Signed positive: `Acc` ≤ 2^(Size−1)−1. Signed negative: `Acc` ≤ 2^(Size−1). Failure sets `ErrFlag`.
  - `Valid`=1 and `Error`=`ErrFlag`.
  - If `ErrFlag`=0, `Data` = `Neg` ? −`Acc` : `Acc`, truncated to `Size` bits. If `ErrFlag`=1, `Data` is unchanged.
  - `Acc`, `Neg` and `ErrFlag` are cleared.

## Timing
- Reset values: `Data`=0, `Valid`=0, `Error`=0. State = COLLECT, `Captured`=0, settle counter=0, `Acc`/`Neg`/`ErrFlag`=0.
- Reset mid-frame or mid-CONVERT aborts immediately. No `Valid` is produced for the partial frame.
- Capture latency: a digit is stored `1+SettleCycles` clock edges after it first appears on the pins (1 input register plus the settle count).
- A select held for fewer than `SettleCycles` cycles is never captured.
- Result latency: `Valid` rises `ISize+1` cycles after the edge that captures the last position.
- `Valid` is never high for two consecutive cycles. The minimum spacing between `Valid` pulses is `ISize+2` cycles.
- `Data` and `Error` change only in the cycle `Valid` is high. Both hold between pulses.
- A display digit stable for `SettleCycles` within an ongoing CONVERT period is missed. It is captured on the next scan pass.

## Test plan
All scenarios use `Size`=4, `Signed`="Yes", `ISize`=2, `SettleCycles`=2, each select held for 3 cycles.
- Positive value: Ind 01/Seg 06, then Ind 10/Seg 00 → one `Valid` pulse with `Data`=4'b0001 and `Error`=0, exactly 3 cycles after the second capture.
- Negative value: Ind 01/Seg 07, then Ind 10/Seg 40 → `Data`=4'b1001 (−7), `Error`=0.
- Range boundary: 8 with minus → `Data`=4'b1000, `Error`=0. Next frame 8 with blank → `Error`=1 and `Data` stays 4'b1000.
- Illegal code: Seg 49 at Ind 01 → `Valid` with `Error`=1 and `Data` unchanged. The next legal frame "3" → `Data`=3, `Error`=0.
- Glitch rejection: Ind 01 held for 1 cycle only, then `Indicators`=00 → no capture and no `Valid`. A non-one-hot Ind 11 for 5 cycles → no capture.
- Reset mid-operation: assert `nReset`=0 during CONVERT → `Data`=0, `Valid`=0, `Error`=0 asynchronously, and no pulse follows release. Then drive a full bench sweep of −7..7, with each value held for a full refresh period → each value is reproduced on `Data` with `Error`=0.
